// File: rtl/imm_field_decode_pkg.sv
// Shared constants for the immediate-field decoder: opcode values, extension
// selector encoding and the buffered entry layout.
package imm_field_decode_pkg;

  localparam int INSTR_W = 16;
  localparam int SRC_W   = 11;
  localparam int SEL_W   = 3;

  localparam logic [4:0] OP_B      = 5'b00010;
  localparam logic [4:0] OP_BEQZ   = 5'b00100;
  localparam logic [4:0] OP_BNEZ   = 5'b00101;
  localparam logic [4:0] OP_SHIFT  = 5'b00110;
  localparam logic [4:0] OP_ADDIU3 = 5'b01000;
  localparam logic [4:0] OP_ADDIU  = 5'b01001;
  localparam logic [4:0] OP_I8     = 5'b01100;
  localparam logic [4:0] OP_LI     = 5'b01101;
  localparam logic [4:0] OP_CMPI   = 5'b01110;
  localparam logic [4:0] OP_LW_SP  = 5'b10010;
  localparam logic [4:0] OP_LW     = 5'b10011;
  localparam logic [4:0] OP_SW_SP  = 5'b11010;
  localparam logic [4:0] OP_SW     = 5'b11011;

  // Sub-opcodes of the 01100 group that carry an 8-bit immediate
  localparam logic [2:0] I8_BTEQZ = 3'b000;
  localparam logic [2:0] I8_ADDSP = 3'b011;

  typedef enum logic [SEL_W-1:0] {
    IM0    = 3'd0,
    IM3    = 3'd1,
    IM4    = 3'd2,
    IM5    = 3'd3,
    IM8    = 3'd4,
    IM11   = 3'd5,
    IM_TO8 = 3'd6
  } imm_sel_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [SRC_W-1:0]   src;
    imm_sel_e           sel;
  } entry_t;

endpackage

// File: rtl/imm_field_decode_sel.sv
// Pure combinational decode of a 16-bit instruction into the raw immediate
// field and the extender selector.
module imm_sel_comb
  import imm_field_decode_pkg::*;
(
  input  logic [INSTR_W-1:0] instr_i,
  output logic [SRC_W-1:0]   src_o,
  output imm_sel_e           sel_o
);

  logic [4:0] op;
  assign op = instr_i[15:11];

  always_comb begin
    src_o = '0;
    sel_o = IM0;
    case (op)
      OP_ADDIU, OP_LI, OP_BEQZ, OP_BNEZ, OP_CMPI, OP_LW_SP, OP_SW_SP: begin
        sel_o = IM8;
        src_o = {3'b0, instr_i[7:0]};
      end
      OP_I8: begin
        if (instr_i[10:8] == I8_BTEQZ || instr_i[10:8] == I8_ADDSP) begin
          sel_o = IM8;
          src_o = {3'b0, instr_i[7:0]};
        end
      end
      OP_B: begin
        sel_o = IM11;
        src_o = instr_i[10:0];
      end
      OP_ADDIU3: begin
        sel_o = IM4;
        src_o = {7'b0, instr_i[3:0]};
      end
      OP_LW, OP_SW: begin
        sel_o = IM5;
        src_o = {6'b0, instr_i[4:0]};
      end
      OP_SHIFT: begin
        // A zero shift amount field encodes a shift by 8
        sel_o = (instr_i[4:2] == 3'b000) ? IM_TO8 : IM3;
        src_o = {6'b0, instr_i[4:0]};
      end
      default: begin
        sel_o = IM0;
        src_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/imm_field_decode.sv
// ID-stage immediate decoder: decodes at push time into a 2-entry FIFO with
// registered ready/valid so IF never sees a combinational ready path.
module imm_field_decode
  import imm_field_decode_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SRC_W-1:0]   out_src,
  output logic [SEL_W-1:0]   out_srcget,
  output logic [INSTR_W-1:0] out_instr
);

  entry_t     mem_q [2];
  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] count_q, count_d;
  logic       in_ready_q, out_valid_q;
  logic       push, pop;

  logic [SRC_W-1:0] dec_src;
  imm_sel_e         dec_sel;

  imm_sel_comb u_sel (
    .instr_i (in_instr),
    .src_o   (dec_src),
    .sel_o   (dec_sel)
  );

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
    end else begin
      count_q     <= count_d;
      in_ready_q  <= (count_d != 2'd2);
      out_valid_q <= (count_d != 2'd0);
      if (flush) begin
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
      end else begin
        if (push) begin
          mem_q[wr_ptr_q] <= '{instr: in_instr, src: dec_src, sel: dec_sel};
          wr_ptr_q        <= ~wr_ptr_q;
        end
        if (pop) rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_src    = mem_q[rd_ptr_q].src;
  assign out_srcget = mem_q[rd_ptr_q].sel;
  assign out_instr  = mem_q[rd_ptr_q].instr;

endmodule

// File: tb/tb_imm_field_decode.sv
// Scoreboard bench for imm_field_decode: directed scenarios then randomized
// traffic against a field-width reference model.
module tb_imm_field_decode;
  import imm_field_decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [15:0] in_instr;
  logic        in_ready, out_valid;
  logic [10:0] out_src;
  logic [2:0]  out_srcget;
  logic [15:0] out_instr;

  int checks = 0;
  int failures = 0;
  int n_push = 0, n_pop = 0, n_drop = 0;

  logic [29:0] exp_q [$];

  imm_field_decode dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_src    (out_src),
    .out_srcget (out_srcget),
    .out_instr  (out_instr)
  );

  always #5 clk = ~clk;

  // Reference: pick the selector from the opcode rules, then keep the low
  // field-width bits of instr[10:0].
  function automatic logic [29:0] ref_decode(input logic [15:0] ins);
    logic [4:0]  op;
    logic [2:0]  sel;
    int          w;
    logic [15:0] mask;
    op  = ins[15:11];
    sel = 3'd0;
    w   = 0;
    if (op inside {5'b01001, 5'b01101, 5'b00100, 5'b00101, 5'b01110, 5'b10010, 5'b11010}) begin
      sel = 3'd4; w = 8;
    end else if (op == 5'b01100) begin
      if (ins[10:8] == 3'b000 || ins[10:8] == 3'b011) begin sel = 3'd4; w = 8; end
    end else if (op == 5'b00010) begin
      sel = 3'd5; w = 11;
    end else if (op == 5'b01000) begin
      sel = 3'd2; w = 4;
    end else if (op inside {5'b10011, 5'b11011}) begin
      sel = 3'd3; w = 5;
    end else if (op == 5'b00110) begin
      sel = (ins[4:2] == 3'b000) ? 3'd6 : 3'd1; w = 5;
    end
    mask = (16'd1 << w) - 16'd1;
    return {ins, sel, ins[10:0] & mask[10:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor / scoreboard, sampled mid-cycle where all handshake signals are settled
  logic        hold_prev = 1'b0;
  logic [29:0] prev_out;
  always @(negedge clk) begin
    if (rst) begin
      n_drop += exp_q.size();
      exp_q.delete();
      hold_prev = 1'b0;
    end else if (flush) begin
      n_drop += exp_q.size();
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_data", {2'd0, out_instr, out_srcget, out_src}, {2'd0, prev_out});
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL pop_unexpected actual=%0h required=none", out_instr);
        end else begin
          logic [29:0] e;
          e = exp_q.pop_front();
          n_pop++;
          if ({out_instr, out_srcget, out_src} !== e) begin
            failures++;
            $display("FAIL pop_data actual=%0h/%0d/%0h required=%0h/%0d/%0h",
                     out_instr, out_srcget, out_src, e[29:14], e[13:11], e[10:0]);
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_decode(in_instr));
        n_push++;
      end
      hold_prev = out_valid && !out_ready;
      prev_out  = {out_instr, out_srcget, out_src};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [15:0] ins);
    int n;
    in_valid = 1'b1;
    in_instr = ins;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL push_timeout actual=in_ready0 required=in_ready1");
    end
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
    #12;
    @(negedge clk);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_srcget", {29'd0, out_srcget}, 32'd0);
    chk("reset_src", {21'd0, out_src}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // ADDIU, 8-bit immediate
    out_ready = 1'b1;
    push_one(16'h4F85);
    @(negedge clk);
    chk("addiu_valid", {31'd0, out_valid}, 32'd1);
    chk("addiu_srcget", {29'd0, out_srcget}, 32'd4);
    chk("addiu_src", {21'd0, out_src}, 32'h085);
    tick(); tick();

    // Shifts: zero amount field means shift by 8
    push_one(16'h3100);
    @(negedge clk);
    chk("sll8_srcget", {29'd0, out_srcget}, 32'd6);
    tick();
    push_one(16'h3108);
    @(negedge clk);
    chk("sll2_srcget", {29'd0, out_srcget}, 32'd1);
    chk("sll2_src", {21'd0, out_src}, 32'h008);
    tick(); tick();

    // Backpressure fills the buffer then drains in order
    out_ready = 1'b0;
    push_one(16'h17FF);
    push_one(16'h9A3F);
    @(negedge clk);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("full_head_srcget", {29'd0, out_srcget}, 32'd5);
    chk("full_head_src", {21'd0, out_src}, 32'h7FF);
    tick();
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("drain2_srcget", {29'd0, out_srcget}, 32'd3);
    chk("drain2_src", {21'd0, out_src}, 32'h01F);
    tick(); tick();

    // Flush at count 2 with a same-cycle push
    out_ready = 1'b0;
    push_one(16'h4801);
    push_one(16'h6C22);
    flush = 1'b1; in_valid = 1'b1; in_instr = 16'h1234;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    tick(); tick(); tick();
    @(negedge clk);
    chk("flush_stays_empty", {31'd0, out_valid}, 32'd0);
    tick();

    // Asynchronous reset mid-cycle with an entry in flight
    out_ready = 1'b0;
    push_one(16'h9A3F);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_src", {21'd0, out_src}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Randomized traffic
    begin
      int cyc;
      int start_push;
      cyc = 0;
      start_push = n_push;
      while (n_push - start_push < 10000 && cyc < 40000) begin
        in_valid  = ($urandom_range(0, 9) < 7);
        in_instr  = 16'($urandom());
        out_ready = ($urandom_range(0, 9) < 6);
        flush     = ($urandom_range(0, 199) == 0);
        tick();
        cyc++;
      end
      flush = 1'b0;
      in_valid = 1'b0;
      chk("random_volume", {31'd0, (n_push - start_push >= 10000)}, 32'd1);
    end

    out_ready = 1'b1;
    begin
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
        tick();
        n++;
      end
    end
    @(negedge clk);
    chk("drain_queue_empty", exp_q.size(), 32'd0);
    chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
    chk("no_loss_or_dup", n_pop + n_drop, n_push);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
